// File: rtl/hsv_core_pkg.sv
// rtl/hsv_core_pkg.sv - shared AXI types and response helpers for the core memory path
//
// Contents:
//   axi_resp_t, axi_burst_t, axi_size_t : AXI4 encodings
//   axi_len_t                            : AXI4 burst length (beats - 1)
//   worst_axi_resp()                     : merge two responses, DECERR > SLVERR > OKAY
package hsv_core_pkg;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [2:0] {
        AXI_SIZE_1   = 3'd0,
        AXI_SIZE_2   = 3'd1,
        AXI_SIZE_4   = 3'd2,
        AXI_SIZE_8   = 3'd3,
        AXI_SIZE_16  = 3'd4,
        AXI_SIZE_32  = 3'd5,
        AXI_SIZE_64  = 3'd6,
        AXI_SIZE_128 = 3'd7
    } axi_size_t;

    typedef logic [7:0] axi_len_t;

    // EXOKAY is never produced by this responder; it merges as OKAY.
    function automatic axi_resp_t worst_axi_resp(input axi_resp_t a, input axi_resp_t b);
        if (a == AXI_RESP_DECERR || b == AXI_RESP_DECERR) return AXI_RESP_DECERR;
        if (a == AXI_RESP_SLVERR || b == AXI_RESP_SLVERR) return AXI_RESP_SLVERR;
        return AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/hsv_axi_burst_addr.sv
// rtl/hsv_axi_burst_addr.sv - combinational AXI4 next-beat address and burst legality
//
// Ports:
//   addr      in  32  address of the current beat
//   size      in  3   beat size (axi_size_t)
//   len       in  8   burst length (axi_len_t)
//   burst     in  2   burst type (axi_burst_t)
//   next_addr out 32  address of the following beat
//   illegal   out 1   burst parameters unsupported (size > 4 bytes, reserved type, bad WRAP length)
//
// Macro HSV_AXI_RAM_WRAP_EN: when undefined the wrap arithmetic is absent and every
// WRAP burst is reported illegal.
module hsv_axi_burst_addr
    import hsv_core_pkg::*;
(
    input  logic [31:0] addr,
    input  axi_size_t   size,
    input  axi_len_t    len,
    input  axi_burst_t  burst,
    output logic [31:0] next_addr,
    output logic        illegal
);

    logic [31:0] incr;
    assign incr = 32'd1 << size;

`ifdef HSV_AXI_RAM_WRAP_EN
    logic        wrap_len_ok;
    logic [31:0] wrap_mask;
    assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    // Window is (len+1)<<size bytes; aligned, so the low bits alone advance.
    assign wrap_mask   = (({24'd0, len} + 32'd1) << size) - 32'd1;
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        illegal   = (size > AXI_SIZE_4) || (burst == AXI_BURST_RSVD);
        next_addr = addr;
        case (burst)
            AXI_BURST_INCR: next_addr = addr + incr;
`ifdef HSV_AXI_RAM_WRAP_EN
            AXI_BURST_WRAP: begin
                next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
                if (!wrap_len_ok) illegal = 1'b1;
            end
`else
            AXI_BURST_WRAP: illegal = 1'b1;
`endif
            default:        next_addr = addr;
        endcase
    end

endmodule

// File: rtl/hsv_axi_ram_responder.sv
// rtl/hsv_axi_ram_responder.sv - AXI4 responder backed by a 32-bit word RAM
//
// Ports:
//   clk_core, rst_core_n             clock, asynchronous active-low reset
//   aw*  (awvalid/awready/awid/awaddr/awlen/awsize/awburst)   write address
//   w*   (wvalid/wready/wdata/wstrb/wlast)                     write data
//   b*   (bvalid/bready/bid/bresp)                              write response
//   ar*  (arvalid/arready/arid/araddr/arlen/arsize/arburst)   read address
//   r*   (rvalid/rready/rid/rdata/rresp/rlast)                 read data
//
// Parameters: DepthWords (power of two), BaseAddr (byte address of word 0), IdWidth.
// Macro HSV_AXI_RAM_WRAP_EN enables WRAP bursts; otherwise they complete with SLVERR.
// One read burst and one write burst may be in flight at once, independently.
module hsv_axi_ram_responder
    import hsv_core_pkg::*;
#(
    parameter int unsigned DepthWords = 4096,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000,
    parameter int unsigned IdWidth    = 4
) (
    input  logic               clk_core,
    input  logic               rst_core_n,

    input  logic               awvalid,
    output logic               awready,
    input  logic [IdWidth-1:0] awid,
    input  logic [31:0]        awaddr,
    input  axi_len_t           awlen,
    input  axi_size_t          awsize,
    input  axi_burst_t         awburst,

    input  logic               wvalid,
    output logic               wready,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               wlast,

    output logic               bvalid,
    input  logic               bready,
    output logic [IdWidth-1:0] bid,
    output axi_resp_t          bresp,

    input  logic               arvalid,
    output logic               arready,
    input  logic [IdWidth-1:0] arid,
    input  logic [31:0]        araddr,
    input  axi_len_t           arlen,
    input  axi_size_t          arsize,
    input  axi_burst_t         arburst,

    output logic               rvalid,
    input  logic               rready,
    output logic [IdWidth-1:0] rid,
    output logic [31:0]        rdata,
    output axi_resp_t          rresp,
    output logic               rlast
);

    localparam int unsigned IdxW     = $clog2(DepthWords);
    localparam logic [32:0] WinBytes = 33'(DepthWords) << 2;

    typedef enum logic       {R_IDLE, R_BURST}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;

    logic [31:0] mem [DepthWords];

    // Offset taken modulo 2^32 so addresses below BaseAddr also land outside.
    function automatic logic in_window(input logic [31:0] a);
        return {1'b0, a - BaseAddr} < WinBytes;
    endfunction

    function automatic logic [IdxW-1:0] ram_index(input logic [31:0] a);
        return IdxW'((a - BaseAddr) >> 2);
    endfunction

    function automatic axi_resp_t beat_resp(input logic [31:0] a, input logic ovf,
                                            input logic illegal);
        if (ovf || !in_window(a)) return AXI_RESP_DECERR;
        if (illegal)              return AXI_RESP_SLVERR;
        return AXI_RESP_OKAY;
    endfunction

    // ------------------------------------------------------------------ read
    r_state_t    r_state;
    axi_len_t    r_len;
    axi_len_t    r_cnt;
    axi_size_t   r_size;
    axi_burst_t  r_burst;
    logic [31:0] r_addr;     // address of the next beat to fetch
    logic        r_ovf;      // r_addr has wrapped past 2^32

    logic [31:0] ra_addr;
    axi_size_t   ra_size;
    axi_len_t    ra_len;
    axi_burst_t  ra_burst;
    logic        ra_ovf;
    logic [31:0] ra_next;
    logic        ra_illegal;
    logic        ra_carry;
    axi_resp_t   r_beat_resp;
    logic        r_issue;

    // Beat 0 is fetched straight from the AR inputs; later beats from the latched command.
    always_comb begin
        if (r_state == R_IDLE) begin
            ra_addr  = araddr;
            ra_size  = arsize;
            ra_len   = arlen;
            ra_burst = arburst;
            ra_ovf   = 1'b0;
        end else begin
            ra_addr  = r_addr;
            ra_size  = r_size;
            ra_len   = r_len;
            ra_burst = r_burst;
            ra_ovf   = r_ovf;
        end
    end

    hsv_axi_burst_addr u_rd_addr (
        .addr      (ra_addr),
        .size      (ra_size),
        .len       (ra_len),
        .burst     (ra_burst),
        .next_addr (ra_next),
        .illegal   (ra_illegal)
    );

    assign ra_carry    = (ra_burst == AXI_BURST_INCR) && (ra_next < ra_addr);
    assign r_beat_resp = beat_resp(ra_addr, ra_ovf, ra_illegal);
    assign r_issue     = ((r_state == R_IDLE)  && arvalid && arready) ||
                         ((r_state == R_BURST) && rvalid && rready && !rlast);

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= AXI_RESP_OKAY;
            rlast   <= 1'b0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= AXI_SIZE_1;
            r_burst <= AXI_BURST_FIXED;
            r_addr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_issue) begin
                rvalid <= 1'b1;
                rresp  <= r_beat_resp;
                rdata  <= (r_beat_resp == AXI_RESP_OKAY) ? mem[ram_index(ra_addr)] : 32'd0;
                r_addr <= ra_next;
                r_ovf  <= ra_ovf || ra_carry;
            end
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        r_state <= R_BURST;
                        rid     <= arid;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_cnt   <= '0;
                        rlast   <= (arlen == 8'd0);
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_BURST: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                            rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- write
    w_state_t    w_state;
    axi_len_t    w_len;
    axi_len_t    w_cnt;
    axi_size_t   w_size;
    axi_burst_t  w_burst;
    logic [31:0] w_addr;     // address of the beat currently accepted
    logic        w_ovf;
    axi_resp_t   w_acc;      // worst response over beats already accepted

    logic [31:0] wa_next;
    logic        wa_illegal;
    logic        wa_carry;
    axi_resp_t   w_beat_resp;
    axi_resp_t   w_beat_worst;
    logic        w_fire;
    logic        w_proto_err;
    logic        ram_we;

    hsv_axi_burst_addr u_wr_addr (
        .addr      (w_addr),
        .size      (w_size),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (wa_next),
        .illegal   (wa_illegal)
    );

    assign wa_carry     = (w_burst == AXI_BURST_INCR) && (wa_next < w_addr);
    assign w_fire       = wvalid && wready;
    assign w_beat_resp  = beat_resp(w_addr, w_ovf, wa_illegal);
    // A misplaced wlast poisons the response but does not block that beat's write.
    assign w_proto_err  = wlast != (w_cnt == w_len);
    assign w_beat_worst = worst_axi_resp(w_beat_resp,
                                         w_proto_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
    assign ram_we       = w_fire && (w_beat_resp == AXI_RESP_OKAY);

    // RAM has no reset; a read in the same cycle sees the pre-write word.
    always_ff @(posedge clk_core) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[ram_index(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= AXI_RESP_OKAY;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= AXI_SIZE_1;
            w_burst <= AXI_BURST_FIXED;
            w_addr  <= '0;
            w_ovf   <= 1'b0;
            w_acc   <= AXI_RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                        bid     <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_ovf   <= 1'b0;
                        w_acc   <= AXI_RESP_OKAY;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_cnt == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= worst_axi_resp(w_acc, w_beat_worst);
                            w_state <= W_RESP;
                        end else begin
                            w_acc  <= worst_axi_resp(w_acc, w_beat_worst);
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= wa_next;
                            w_ovf  <= w_ovf || wa_carry;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_axi_ram_responder.sv
// tb/tb_hsv_axi_ram_responder.sv - directed self-checking bench for hsv_axi_ram_responder
module tb_hsv_axi_ram_responder;
    import hsv_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
    logic [3:0]  awid = 0, bid, arid = 0, rid, wstrb = 0;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
    axi_len_t    awlen = 0, arlen = 0;
    axi_size_t   awsize = AXI_SIZE_4, arsize = AXI_SIZE_4;
    axi_burst_t  awburst = AXI_BURST_INCR, arburst = AXI_BURST_INCR;
    axi_resp_t   bresp, rresp;
    logic        arvalid = 0, arready, rvalid, rready = 0, rlast;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] rd_data [16];
    axi_resp_t   rd_resp [16];
    logic        rd_last [16];
    int          rd_cyc  [16];
    int          rd_n, hold_bad, wr_beats;
    logic        to_flag;
    logic [31:0] wr_data [16];
    axi_resp_t   wr_bresp;
    logic [3:0]  wr_bid;

    always #5 clk = ~clk;

    hsv_axi_ram_responder dut (
        .clk_core(clk), .rst_core_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input axi_len_t len,
                               input axi_size_t size, input axi_burst_t burst,
                               input logic [3:0] strb, input int last_beat);
        int n;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) to_flag = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0;
        wr_beats = 0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wr_data[b % 16]; wstrb = strb; wlast = (b == last_beat); wvalid = 1;
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (!wready) to_flag = 1; else wr_beats++;
            @(posedge clk); @(negedge clk);
        end
        wvalid = 0; wlast = 0; bready = 1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) to_flag = 1;
        wr_bresp = bresp; wr_bid = bid;
        @(posedge clk); @(negedge clk);
        bready = 0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input axi_len_t len,
                           input axi_size_t size, input axi_burst_t burst);
        int n;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) to_flag = 1;
        @(posedge clk); @(negedge clk);
        arvalid = 0;
    endtask

    task automatic collect_r(input logic [3:0] pat);
        logic        stalled, done;
        logic [31:0] held;
        rd_n = 0; hold_bad = 0; stalled = 0; done = 0; held = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            rready = pat[c % 4];
            if (rvalid) begin
                if (stalled && rdata !== held) hold_bad++;
                if (rready) begin
                    if (rd_n < 16) begin
                        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp;
                        rd_last[rd_n] = rlast; rd_cyc[rd_n] = c;
                    end
                    rd_n++;
                    stalled = 0;
                    if (rlast) done = 1;
                end else begin
                    stalled = 1; held = rdata;
                end
            end
            @(posedge clk); @(negedge clk);
        end
        rready = 0;
        if (!done) to_flag = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0)
            $display("FAIL reset_outputs got=%b exp=000000", {awready, arready, wready, bvalid, rvalid, rlast});
        else pass_cnt++;
        chk_cnt++;
        if (rdata !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", rdata); else pass_cnt++;
        rst_n = 1;
        #1;
        chk_cnt++;
        if (arready !== 1'b0) $display("FAIL reset_arready_before_edge got=%b exp=0", arready); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if ({awready, arready} !== 2'b11) $display("FAIL reset_ready_after_edge got=%b exp=11", {awready, arready});
        else pass_cnt++;
    endtask

    task automatic test_incr_write_read();
        to_flag = 0;
        for (int i = 0; i < 4; i++) wr_data[i] = i + 1;
        write_burst(4'd3, 32'h100, 8'd3, AXI_SIZE_4, AXI_BURST_INCR, 4'hF, 3);
        chk_cnt++;
        if (wr_bresp !== AXI_RESP_OKAY) $display("FAIL incr_bresp got=%0d exp=0", wr_bresp); else pass_cnt++;
        chk_cnt++;
        if (wr_bid !== 4'd3) $display("FAIL incr_bid got=%0d exp=3", wr_bid); else pass_cnt++;
        send_ar(4'd5, 32'h100, 8'd3, AXI_SIZE_4, AXI_BURST_INCR);
        chk_cnt++;
        if (rid !== 4'd5) $display("FAIL incr_rid got=%0d exp=5", rid); else pass_cnt++;
        collect_r(4'b1111);
        chk_cnt++;
        if (rd_n !== 4) $display("FAIL incr_beats got=%0d exp=4", rd_n); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (rd_data[i] !== 32'(i + 1) || rd_resp[i] !== AXI_RESP_OKAY || rd_last[i] !== (i == 3))
                $display("FAIL incr_beat%0d got=%h/%0d/%b exp=%h/0/%b", i, rd_data[i], rd_resp[i], rd_last[i], i + 1, i == 3);
            else pass_cnt++;
        end
        chk_cnt++;
        if (rd_cyc[3] - rd_cyc[0] !== 3) $display("FAIL incr_consecutive got=%0d exp=3", rd_cyc[3] - rd_cyc[0]);
        else pass_cnt++;
        chk_cnt++;
        if (rvalid !== 1'b0) $display("FAIL incr_no_extra_beat got=%b exp=0", rvalid); else pass_cnt++;
        chk_cnt++;
        if (to_flag !== 1'b0) $display("FAIL incr_timeout got=%b exp=0", to_flag); else pass_cnt++;
    endtask

    task automatic test_rready_stall();
        to_flag = 0;
        send_ar(4'd1, 32'h100, 8'd3, AXI_SIZE_4, AXI_BURST_INCR);
        collect_r(4'b1001);
        chk_cnt++;
        if (rd_n !== 4) $display("FAIL stall_beats got=%0d exp=4", rd_n); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (rd_data[i] !== 32'(i + 1)) $display("FAIL stall_beat%0d got=%h exp=%h", i, rd_data[i], i + 1);
            else pass_cnt++;
        end
        chk_cnt++;
        if (hold_bad !== 0) $display("FAIL stall_hold got=%0d exp=0", hold_bad); else pass_cnt++;
        chk_cnt++;
        if (to_flag !== 1'b0) $display("FAIL stall_timeout got=%b exp=0", to_flag); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [4];
        axi_resp_t   exp_r;
        to_flag = 0;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hA000_0000 + i;
        write_burst(4'd2, 32'h10, 8'd3, AXI_SIZE_4, AXI_BURST_INCR, 4'hF, 3);
`ifdef HSV_AXI_RAM_WRAP_EN
        exp_d[0] = 32'hA000_0003; exp_d[1] = 32'hA000_0000;
        exp_d[2] = 32'hA000_0001; exp_d[3] = 32'hA000_0002;
        exp_r = AXI_RESP_OKAY;
`else
        for (int i = 0; i < 4; i++) exp_d[i] = 32'd0;
        exp_r = AXI_RESP_SLVERR;
`endif
        send_ar(4'd0, 32'h1C, 8'd3, AXI_SIZE_4, AXI_BURST_WRAP);
        collect_r(4'b1111);
        chk_cnt++;
        if (rd_n !== 4) $display("FAIL wrap_beats got=%0d exp=4", rd_n); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (rd_data[i] !== exp_d[i] || rd_resp[i] !== exp_r || rd_last[i] !== (i == 3))
                $display("FAIL wrap_beat%0d got=%h/%0d/%b exp=%h/%0d/%b", i, rd_data[i], rd_resp[i], rd_last[i], exp_d[i], exp_r, i == 3);
            else pass_cnt++;
        end
        chk_cnt++;
        if (to_flag !== 1'b0) $display("FAIL wrap_timeout got=%b exp=0", to_flag); else pass_cnt++;
    endtask

    task automatic test_window_edge();
        to_flag = 0;
        wr_data[0] = 32'hCAFE_0001; wr_data[1] = 32'hCAFE_0002;
        write_burst(4'd7, 32'h3FFC, 8'd1, AXI_SIZE_4, AXI_BURST_INCR, 4'hF, 1);
        chk_cnt++;
        if (wr_bresp !== AXI_RESP_DECERR) $display("FAIL edge_bresp got=%0d exp=3", wr_bresp); else pass_cnt++;
        send_ar(4'd0, 32'h3FFC, 8'd1, AXI_SIZE_4, AXI_BURST_INCR);
        collect_r(4'b1111);
        chk_cnt++;
        if (rd_data[0] !== 32'hCAFE_0001 || rd_resp[0] !== AXI_RESP_OKAY)
            $display("FAIL edge_beat0 got=%h/%0d exp=cafe0001/0", rd_data[0], rd_resp[0]);
        else pass_cnt++;
        chk_cnt++;
        if (rd_data[1] !== 32'd0 || rd_resp[1] !== AXI_RESP_DECERR || rd_last[1] !== 1'b1)
            $display("FAIL edge_beat1 got=%h/%0d/%b exp=0/3/1", rd_data[1], rd_resp[1], rd_last[1]);
        else pass_cnt++;
        chk_cnt++;
        if (to_flag !== 1'b0) $display("FAIL edge_timeout got=%b exp=0", to_flag); else pass_cnt++;
    endtask

    task automatic test_wlast_early();
        to_flag = 0;
        for (int i = 0; i < 3; i++) wr_data[i] = 32'h5000 + i;
        write_burst(4'd4, 32'h200, 8'd2, AXI_SIZE_4, AXI_BURST_INCR, 4'hF, 1);
        chk_cnt++;
        if (wr_beats !== 3) $display("FAIL wlast_beats got=%0d exp=3", wr_beats); else pass_cnt++;
        chk_cnt++;
        if (wr_bresp !== AXI_RESP_SLVERR) $display("FAIL wlast_bresp got=%0d exp=2", wr_bresp); else pass_cnt++;
        chk_cnt++;
        if (to_flag !== 1'b0) $display("FAIL wlast_timeout got=%b exp=0", to_flag); else pass_cnt++;
    endtask

    task automatic test_strobe_size_fixed();
        to_flag = 0;
        wr_data[0] = 32'hFFFF_FFFF;
        write_burst(4'd0, 32'h300, 8'd0, AXI_SIZE_4, AXI_BURST_INCR, 4'hF, 0);
        wr_data[0] = 32'h1234_5678;
        write_burst(4'd0, 32'h300, 8'd0, AXI_SIZE_4, AXI_BURST_INCR, 4'b0101, 0);
        send_ar(4'd0, 32'h300, 8'd0, AXI_SIZE_4, AXI_BURST_INCR);
        collect_r(4'b1111);
        chk_cnt++;
        if (rd_data[0] !== 32'hFF34_FF78 || rd_last[0] !== 1'b1)
            $display("FAIL strobe_merge got=%h/%b exp=ff34ff78/1", rd_data[0], rd_last[0]);
        else pass_cnt++;
        send_ar(4'd0, 32'h100, 8'd0, AXI_SIZE_8, AXI_BURST_INCR);
        collect_r(4'b1111);
        chk_cnt++;
        if (rd_data[0] !== 32'd0 || rd_resp[0] !== AXI_RESP_SLVERR)
            $display("FAIL size8_read got=%h/%0d exp=0/2", rd_data[0], rd_resp[0]);
        else pass_cnt++;
        wr_data[0] = 32'hDEAD_BEEF;
        write_burst(4'd0, 32'h100, 8'd0, AXI_SIZE_4, AXI_BURST_RSVD, 4'hF, 0);
        chk_cnt++;
        if (wr_bresp !== AXI_RESP_SLVERR) $display("FAIL rsvd_bresp got=%0d exp=2", wr_bresp); else pass_cnt++;
        send_ar(4'd0, 32'h104, 8'd2, AXI_SIZE_4, AXI_BURST_FIXED);
        collect_r(4'b1111);
        chk_cnt++;
        if (rd_n !== 3 || rd_data[0] !== 32'd2 || rd_data[1] !== 32'd2 || rd_data[2] !== 32'd2)
            $display("FAIL fixed_read got=%0d:%h,%h,%h exp=3:2,2,2", rd_n, rd_data[0], rd_data[1], rd_data[2]);
        else pass_cnt++;
        chk_cnt++;
        if (to_flag !== 1'b0) $display("FAIL strobe_timeout got=%b exp=0", to_flag); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        to_flag = 0;
        wr_data[0] = 32'h7700_0000; wr_data[1] = 32'h7700_0001;
        fork
            write_burst(4'd9, 32'h400, 8'd1, AXI_SIZE_4, AXI_BURST_INCR, 4'hF, 1);
            begin
                send_ar(4'd6, 32'h100, 8'd3, AXI_SIZE_4, AXI_BURST_INCR);
                collect_r(4'b1111);
            end
        join
        chk_cnt++;
        if (wr_bresp !== AXI_RESP_OKAY || wr_bid !== 4'd9)
            $display("FAIL b2b_bresp got=%0d/%0d exp=0/9", wr_bresp, wr_bid);
        else pass_cnt++;
        chk_cnt++;
        if (rd_n !== 4 || rd_data[0] !== 32'd1 || rd_data[3] !== 32'd4 || rd_cyc[3] - rd_cyc[0] !== 3)
            $display("FAIL b2b_read got=%0d:%h..%h span=%0d exp=4:1..4 span=3", rd_n, rd_data[0], rd_data[3], rd_cyc[3] - rd_cyc[0]);
        else pass_cnt++;
        chk_cnt++;
        if (to_flag !== 1'b0) $display("FAIL b2b_timeout got=%b exp=0", to_flag); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        to_flag = 0;
        send_ar(4'd2, 32'h100, 8'd3, AXI_SIZE_4, AXI_BURST_INCR);
        rready = 0;
        chk_cnt++;
        if (rvalid !== 1'b1) $display("FAIL midrst_pre_rvalid got=%b exp=1", rvalid); else pass_cnt++;
        #2 rst_n = 0;
        #1;
        chk_cnt++;
        if ({rvalid, arready, rdata} !== 34'd0)
            $display("FAIL midrst_async got=%b/%b/%h exp=0/0/0", rvalid, arready, rdata);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1;
        #1;
        chk_cnt++;
        if (arready !== 1'b0) $display("FAIL midrst_arready_early got=%b exp=0", arready); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (arready !== 1'b1 || rvalid !== 1'b0)
            $display("FAIL midrst_arready_edge got=%b/%b exp=1/0", arready, rvalid);
        else pass_cnt++;
        send_ar(4'd3, 32'h100, 8'd1, AXI_SIZE_4, AXI_BURST_INCR);
        collect_r(4'b1111);
        chk_cnt++;
        if (rd_n !== 2 || rd_data[0] !== 32'd1 || rd_data[1] !== 32'd2 || rd_last[1] !== 1'b1)
            $display("FAIL midrst_new_burst got=%0d:%h,%h exp=2:1,2", rd_n, rd_data[0], rd_data[1]);
        else pass_cnt++;
        chk_cnt++;
        if (to_flag !== 1'b0) $display("FAIL midrst_timeout got=%b exp=0", to_flag); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_incr_write_read();
        test_rready_stall();
        test_wrap();
        test_window_edge();
        test_wlast_early();
        test_strobe_size_fixed();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
